// File: rtl/runner_pkg.sv
// Shared state encoding and default widths for the processor run controller.
package runner_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PRST,
        RUN,
        RADDR,
        RWAIT,
        OUT
    } runner_state_t;

    localparam int DEF_D          = 8;
    localparam int DEF_LOAD_WORDS = 64;
    localparam int DEF_RES_BASE   = 64;
    localparam int DEF_RES_WORDS  = 4;
    localparam int DEF_CW         = 16;
    localparam int DEF_TIMEOUT    = 4096;

endpackage

// File: rtl/proc_runner_if.sv
// Bundle of the runner's preload stream, data-memory port, core control and result stream.
interface proc_runner_if #(
    parameter int D = 8
);
    logic         load_valid;
    logic [D-1:0] load_data;
    logic         load_ready;

    logic         mem_sel;
    logic         mem_we;
    logic [D-1:0] mem_addr;
    logic [D-1:0] mem_wdata;
    logic [D-1:0] mem_rdata;

    logic         proc_reset;
    logic         proc_start;
    logic         proc_done;

    logic         res_valid;
    logic [D-1:0] res_data;
    logic         res_ready;

    modport master (
        input  load_valid, load_data, mem_rdata, proc_done, res_ready,
        output load_ready, mem_sel, mem_we, mem_addr, mem_wdata,
               proc_reset, proc_start, res_valid, res_data
    );

    modport slave (
        output load_valid, load_data, mem_rdata, proc_done, res_ready,
        input  load_ready, mem_sel, mem_we, mem_addr, mem_wdata,
               proc_reset, proc_start, res_valid, res_data
    );
endinterface

// File: rtl/runner_skid.sv
// One-entry result register: loaded from memory read data, emptied by a valid/ready handshake.
module runner_skid
    import runner_pkg::*;
#(
    parameter int D = DEF_D
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [D-1:0] data_i,
    output logic         valid_o,
    output logic [D-1:0] data_o,
    input  logic         ready_i
);
    logic         valid_q, valid_d;
    logic [D-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/proc_runner.sv
// Run controller: preload data memory, reset and run the core, then drain a result window.
// Optional cycle watchdog is compiled in with PROC_RUNNER_TIMEOUT_EN.
module proc_runner
    import runner_pkg::*;
#(
    parameter int D          = DEF_D,
    parameter int LOAD_WORDS = DEF_LOAD_WORDS,
    parameter int RES_BASE   = DEF_RES_BASE,
    parameter int RES_WORDS  = DEF_RES_WORDS,
    parameter int CW         = DEF_CW,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go,
    proc_runner_if.master bus,
    output logic          busy,
    output logic          timeout,
    output logic [CW-1:0] cycle_count
);
    runner_state_t state_q, state_d;
    logic [D-1:0]  load_idx_q, load_idx_d;
    logic [D-1:0]  rd_idx_q, rd_idx_d;
    logic [CW-1:0] cycle_q, cycle_d, cycle_inc;
    logic          timeout_q, timeout_d;
    logic [D-1:0]  rd_addr;
    logic          capture;
    logic          res_valid;
    logic          res_fire;

    // Window address wraps naturally at 2^D.
    assign rd_addr   = D'(RES_BASE) + rd_idx_q;
    assign cycle_inc = (cycle_q == '1) ? cycle_q : cycle_q + CW'(1);
    assign res_fire  = res_valid && bus.res_ready;

    always_comb begin
        state_d        = state_q;
        load_idx_d     = load_idx_q;
        rd_idx_d       = rd_idx_q;
        cycle_d        = cycle_q;
        timeout_d      = timeout_q;
        capture        = 1'b0;
        bus.load_ready = 1'b0;
        bus.mem_sel    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.proc_reset = 1'b0;
        bus.proc_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    state_d    = LOAD;
                    load_idx_d = '0;
                    rd_idx_d   = '0;
                    cycle_d    = '0;
                    timeout_d  = 1'b0;
                end
            end
            LOAD: begin
                bus.load_ready = 1'b1;
                bus.mem_sel    = 1'b1;
                if (bus.load_valid) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_addr  = load_idx_q;
                    bus.mem_wdata = bus.load_data;
                    load_idx_d    = load_idx_q + D'(1);
                    if (load_idx_q == D'(LOAD_WORDS - 1)) begin
                        state_d = PRST;
                    end
                end
            end
            PRST: begin
                bus.proc_reset = 1'b1;
                state_d        = RUN;
            end
            RUN: begin
                // The done cycle itself is counted, so proc_start drops on the sampling edge.
                bus.proc_start = 1'b1;
                cycle_d        = cycle_inc;
                if (bus.proc_done) begin
                    state_d = RADDR;
                end
`ifdef PROC_RUNNER_TIMEOUT_EN
                else if (cycle_inc == CW'(TIMEOUT)) begin
                    state_d   = RADDR;
                    timeout_d = 1'b1;
                end
`endif
            end
            RADDR: begin
                bus.mem_sel  = 1'b1;
                bus.mem_addr = rd_addr;
                state_d      = RWAIT;
            end
            RWAIT: begin
                bus.mem_sel  = 1'b1;
                bus.mem_addr = rd_addr;
                capture      = 1'b1;
                state_d      = OUT;
            end
            OUT: begin
                bus.mem_sel = 1'b1;
                if (res_fire) begin
                    rd_idx_d = rd_idx_q + D'(1);
                    state_d  = (rd_idx_q == D'(RES_WORDS - 1)) ? IDLE : RADDR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            load_idx_q <= '0;
            rd_idx_q   <= '0;
            cycle_q    <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_idx_q <= load_idx_d;
            rd_idx_q   <= rd_idx_d;
            cycle_q    <= cycle_d;
            timeout_q  <= timeout_d;
        end
    end

    runner_skid #(.D(D)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (capture),
        .data_i  (bus.mem_rdata),
        .valid_o (res_valid),
        .data_o  (bus.res_data),
        .ready_i (bus.res_ready)
    );

    assign bus.res_valid = res_valid;
    assign busy          = (state_q != IDLE);
    assign timeout       = timeout_q;
    assign cycle_count   = cycle_q;
endmodule

// File: doc/proc_runner.md
# proc_runner

Upstream run controller for the 8-bit processor core. It accepts a byte stream over a valid/ready port and preloads it into data memory, then resets and starts the core and counts cycles until `done`. Afterwards it reads a fixed result window back out of data memory over a valid/ready port. It owns the data-memory port whenever the core is not running, and it replaces the bench's hand-driven `start`/`reset`.

## Interface
- `D`, 8: data and address width.
- `LOAD_WORDS`, 64: bytes written per run, to addresses 0..LOAD_WORDS-1 (1..2^D).
- `RES_BASE`, 64: first data-memory address of the result window.
- `RES_WORDS`, 4: bytes read back per run (1..2^D).
- `CW`, 16: cycle-counter width.
- `TIMEOUT`, 4096: run-cycle limit; only used when the watchdog is compiled in.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `go` in 1: single-cycle request to begin a run; sampled only in IDLE.
- `load_valid` in 1, `load_data` in D, `load_ready` out 1: preload stream.
- `mem_sel` out 1: high when the runner owns the data-memory port.
- `mem_we` out 1, `mem_addr` out D, `mem_wdata` out D: memory write and read request.
- `mem_rdata` in D: read data, valid one cycle after `mem_addr` is presented.
- `proc_reset` out 1: core reset.
- `proc_start` out 1: core enable.
- `proc_done` in 1: core halt flag (a level).
- `res_valid` out 1, `res_data` out D, `res_ready` in 1: result stream.
- `busy` out 1: high in every state except IDLE.
- `timeout` out 1: sticky watchdog flag; cleared by `go`.
- `cycle_count` out CW: number of RUN cycles in the last run; held until the next `go`.

## Operation
- States:
  - IDLE: on `go`, go to LOAD, clear `cycle_count` and `timeout`.
  - LOAD: go to PRST after LOAD_WORDS accepted beats.
  - PRST: stay exactly 1 cycle, then go to RUN.
  - RUN: on `proc_done` or watchdog expiry, go to RADDR.
  - RADDR → RWAIT → OUT; OUT returns to RADDR, or to IDLE after the RES_WORDS-th handshake.
- LOAD:
  - `load_ready`=1 and `mem_sel`=1.
  - Each beat with `load_valid&&load_ready` drives `mem_we`=1, `mem_addr`=load index, `mem_wdata`=`load_data` in the same cycle, combinationally.
  - The index starts at 0 and increments per beat. Stalls (`load_valid`=0) are unlimited.
- PRST: `proc_reset`=1, `mem_sel`=0.
- RUN:
  - `proc_start`=1, `mem_sel`=0.
  - `cycle_count` increments every RUN cycle and saturates at all-ones; it does not wrap.
  - A `proc_done` already high on the first RUN cycle ends the run with `cycle_count`=1.
- RADDR: `mem_sel`=1, `mem_addr`=RES_BASE+read index, modulo 2^D, so the window wraps past address 255.
- RWAIT: capture `mem_rdata` into the output register.
- OUT:
  - `res_valid`=1 and `res_data` stays stable until `res_ready`.
  - A handshake increments the read index.
  - `res_ready` held low stalls the runner indefinitely.
- `go` outside IDLE is ignored.
- `load_valid` outside LOAD is ignored, because `load_ready`=0.
- `reset` in any state returns to IDLE on the next edge and aborts the run without finishing the load or drain.

## Timing
- Reset values: state IDLE, `busy`=0, `load_ready`=0, `mem_sel`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `proc_reset`=0, `proc_start`=0, `res_valid`=0, `res_data`=0, `timeout`=0, `cycle_count`=0.
- `go` at edge N gives `busy`=1 and `load_ready`=1 from cycle N+1.
- Minimum run length is LOAD_WORDS + 1 (PRST) + RUN cycles + 3·RES_WORDS with no stalls.
- `proc_start` falls on the same edge that `proc_done` is sampled high. The core is therefore never enabled past its halt by more than the cycle in which `done` was sampled.
- `cycle_count` and `timeout` are final on entry to RADDR.

## Configuration
- `PROC_RUNNER_TIMEOUT_EN` defined:
  - RUN also exits when `cycle_count` reaches TIMEOUT without `proc_done`.
  - The runner then sets `timeout`=1 and still drains the result window.
- Not defined:
  - `timeout` is tied to 0 and TIMEOUT is unused.
  - RUN waits on `proc_done` forever; `cycle_count` still saturates.

## Structure
- `runner_pkg`: state enum `runner_state_t` (IDLE, LOAD, PRST, RUN, RADDR, RWAIT, OUT) and default width constants.
- One sub-module, `runner_skid`: a 1-entry output register with a valid/ready handshake, loaded from `mem_rdata` in RWAIT.
- Index counters and the FSM stay in `proc_runner`.

## Test plan
- Default params, `go`, 64 bytes 0x00..0x3F with no stalls, stub core raises `proc_done` 10 cycles after start → memory holds addr i = i, `cycle_count`=10, 4 results read from addresses 64..67, `busy` drops after the 4th handshake.
- Random `load_valid` gaps of 0–5 cycles → the same writes in order, no extra `mem_we` pulses.
- `res_ready` low for 7 cycles in OUT → `res_data` stable and `res_valid` held, then 4 ordered results.
- RES_BASE=254, RES_WORDS=4 → read addresses 254, 255, 0, 1.
- With `PROC_RUNNER_TIMEOUT_EN`, TIMEOUT=20, core never done → exit after 20 RUN cycles, `timeout`=1, drain still completes. Without the macro → still in RUN after 5000 cycles, `cycle_count`=5000.
- `reset` asserted mid-LOAD (beat 30) and mid-RUN → next cycle IDLE with all outputs at reset values; a following `go` completes a normal run.
